// File: rtl/exe_stage_mc.sv
// Execute stage: operand forwarding, operand-2 generation, single-cycle ALU and an
// iterative shift-add multiplier, all behind a valid/ready EXE/MEM output register.
module exe_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int FWD_SRC  = 2,
    parameter int MUL_BITS = 4,
    parameter int SEL_W    = $clog2(FWD_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic [3:0]                exe_cmd,
    input  logic                      wb_en_in,
    input  logic                      mem_r_en_in,
    input  logic                      mem_w_en_in,
    input  logic                      s_in,
    input  logic [DATA_W-1:0]         pc_in,
    input  logic [DATA_W-1:0]         val_rn,
    input  logic [DATA_W-1:0]         val_rm,
    input  logic                      imm,
    input  logic [11:0]               shift_operand,
    input  logic [23:0]               imm_signed_24,
    input  logic [3:0]                sr_in,
    input  logic [3:0]                dest_in,
    input  logic [SEL_W-1:0]          sel_src_1,
    input  logic [SEL_W-1:0]          sel_src_2,
    input  logic [FWD_SRC*DATA_W-1:0] fwd_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         alu_result,
    output logic [DATA_W-1:0]         br_addr,
    output logic [DATA_W-1:0]         val_rm_out,
    output logic [3:0]                status,
    output logic                      status_we,
    output logic [3:0]                dest,
    output logic                      wb_en,
    output logic                      mem_r_en,
    output logic                      mem_w_en,
    output logic                      busy
);
    localparam int K   = DATA_W / MUL_BITS;
    localparam int SHW = $clog2(DATA_W);
    localparam int CW  = (K > 1) ? $clog2(K) : 1;

    localparam logic [3:0] CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111, CMD_EOR = 4'b1000, CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   mcand_q, mplier_q, acc_q;
    logic [DATA_W-1:0]   p_br_q, p_rm_q;
    logic [1:0]          p_cv_q;
    logic                p_s_q, p_wb_q, p_mr_q, p_mw_q;
    logic [3:0]          p_dest_q;

    logic                out_valid_q, s_q, wb_q, mr_q, mw_q;
    logic [DATA_W-1:0]   res_q, br_q, rm_q;
    logic [3:0]          status_q, dest_q;

    logic [DATA_W-1:0]   rn_f, rm_f, val2, imm_ext, b_op, alu_res, br_calc;
    logic [DATA_W:0]     sum;
    logic [SHW-1:0]      sh_amt, rot_amt;
    logic [3:0]          alu_flags;
    logic                cin, arith, accept, load_alu, load_mul, start_mul;

    function automatic logic [DATA_W-1:0] fwd_pick(input logic [SEL_W-1:0] sel,
                                                   input logic [DATA_W-1:0] reg_val,
                                                   input logic [FWD_SRC*DATA_W-1:0] srcs);
        fwd_pick = reg_val;
        for (int k = 1; k <= FWD_SRC; k++)
            if (int'(sel) == k) fwd_pick = srcs[(k-1)*DATA_W +: DATA_W];
    endfunction

    // Operand selection, operand 2 and the single-cycle ALU.
    always_comb begin
        rn_f    = fwd_pick(sel_src_1, val_rn, fwd_val);
        rm_f    = fwd_pick(sel_src_2, val_rm, fwd_val);
        sh_amt  = SHW'(32'(shift_operand[11:7]) % DATA_W);
        rot_amt = SHW'((32'(shift_operand[11:8]) << 1) % DATA_W);
        imm_ext = DATA_W'(shift_operand[7:0]);
        val2    = '0;
        if (mem_r_en_in | mem_w_en_in) begin
            val2 = DATA_W'(shift_operand);
        end else if (imm) begin
            val2 = (imm_ext >> rot_amt) | (imm_ext << (DATA_W - 32'(rot_amt)));
        end else begin
            unique case (shift_operand[6:5])
                2'b00:   val2 = rm_f << sh_amt;
                2'b01:   val2 = rm_f >> sh_amt;
                2'b10:   val2 = $signed(rm_f) >>> sh_amt;
                default: val2 = (rm_f >> sh_amt) | (rm_f << (DATA_W - 32'(sh_amt)));
            endcase
        end

        b_op      = val2;
        cin       = 1'b0;
        arith     = 1'b0;
        alu_res   = '0;
        alu_flags = sr_in;
        unique case (exe_cmd)
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = sr_in[1]; end
            CMD_SUB: begin arith = 1'b1; b_op = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; b_op = ~val2; cin = sr_in[1]; end
            default: ;
        endcase
        // Subtraction is rn + ~val2 + cin, so the carry out is the ARM "no borrow" C.
        sum = {1'b0, rn_f} + {1'b0, b_op} + (DATA_W+1)'(cin);
        unique case (exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = rn_f & val2;
            CMD_ORR: alu_res = rn_f | val2;
            CMD_EOR: alu_res = rn_f ^ val2;
            default: alu_res = arith ? sum[DATA_W-1:0] : '0;
        endcase
        if (arith)
            alu_flags = {alu_res[DATA_W-1], alu_res == '0, sum[DATA_W],
                         (rn_f[DATA_W-1] == b_op[DATA_W-1]) && (alu_res[DATA_W-1] != rn_f[DATA_W-1])};
        else if (exe_cmd inside {CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR})
            alu_flags = {alu_res[DATA_W-1], alu_res == '0, sr_in[1:0]};

        br_calc = pc_in + DATA_W'($signed({imm_signed_24, 2'b00}));
    end

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // valid never depends on ready, and the output register holds while valid & ~ready.
    always_comb begin
        state_d   = state_q;
        in_ready  = rst & ~flush & (state_q == S_IDLE) & (~out_valid_q | out_ready);
        accept    = in_valid & in_ready;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        start_mul = 1'b0;
        unique case (state_q)
            S_IDLE: if (accept) begin
                if (exe_cmd == CMD_MUL) begin
                    start_mul = 1'b1;
                    state_d   = S_MUL;
                end else begin
                    load_alu = 1'b1;
                end
            end
            S_MUL:  if (cnt_q == CW'(K - 1)) state_d = S_DONE;
            S_DONE: if (~out_valid_q | out_ready) begin
                load_mul = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            load_mul = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;    cnt_q    <= '0;
            mcand_q  <= '0;        mplier_q <= '0;    acc_q  <= '0;
            p_br_q   <= '0;        p_rm_q   <= '0;    p_cv_q <= '0;
            p_s_q    <= 1'b0;      p_wb_q   <= 1'b0;  p_mr_q <= 1'b0;
            p_mw_q   <= 1'b0;      p_dest_q <= '0;
            out_valid_q <= 1'b0;   res_q    <= '0;    br_q   <= '0;
            rm_q     <= '0;        status_q <= '0;    s_q    <= 1'b0;
            dest_q   <= '0;        wb_q     <= 1'b0;  mr_q   <= 1'b0;
            mw_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush)                      out_valid_q <= 1'b0;
            else if (load_alu | load_mul)   out_valid_q <= 1'b1;
            else if (out_ready)             out_valid_q <= 1'b0;

            if (load_alu) begin
                res_q  <= alu_res;   status_q <= alu_flags; br_q <= br_calc;
                rm_q   <= rm_f;      s_q      <= s_in;      dest_q <= dest_in;
                wb_q   <= wb_en_in;  mr_q     <= mem_r_en_in; mw_q <= mem_w_en_in;
            end
            if (load_mul) begin
                res_q  <= acc_q;     status_q <= {acc_q[DATA_W-1], acc_q == '0, p_cv_q};
                br_q   <= p_br_q;    rm_q     <= p_rm_q;    s_q    <= p_s_q;
                dest_q <= p_dest_q;  wb_q     <= p_wb_q;    mr_q   <= p_mr_q;
                mw_q   <= p_mw_q;
            end

            if (start_mul) begin
                mcand_q <= rn_f;     mplier_q <= val2;      acc_q  <= '0;
                cnt_q   <= '0;       p_br_q   <= br_calc;   p_rm_q <= rm_f;
                p_cv_q  <= sr_in[1:0]; p_s_q  <= s_in;      p_dest_q <= dest_in;
                p_wb_q  <= wb_en_in; p_mr_q   <= mem_r_en_in; p_mw_q <= mem_w_en_in;
            end else if (flush) begin
                acc_q <= '0;
            end else if (state_q == S_MUL) begin
                // Multiplicand is pre-shifted, so each step adds mcand * digit << cnt*MUL_BITS.
                acc_q    <= acc_q + mcand_q * DATA_W'(mplier_q[MUL_BITS-1:0]);
                mcand_q  <= mcand_q << MUL_BITS;
                mplier_q <= mplier_q >> MUL_BITS;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = res_q;
    assign br_addr    = br_q;
    assign val_rm_out = rm_q;
    assign status     = status_q;
    assign status_we  = s_q & out_valid_q;
    assign dest       = dest_q;
    assign wb_en      = wb_q;
    assign mem_r_en   = mr_q;
    assign mem_w_en   = mw_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: directed scenario tasks plus a randomized run scored
// against an arithmetic reference model of the execute stage.
module tb_exe_stage_mc;
    localparam int DW = 32;

    typedef struct {
        logic [3:0]  cmd;
        logic        wb, mr, mw, s, imm;
        logic [31:0] pc, rn, rm;
        logic [11:0] so;
        logic [23:0] imm24;
        logic [3:0]  sr, dst;
        logic [1:0]  sel1, sel2;
        logic [63:0] fwd;
    } op_t;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  st;
        logic [31:0] br;
        logic [31:0] rmo;
        logic        swe;
        logic [3:0]  dst;
        logic        wb, mr, mw;
    } exp_t;

    logic          clk, rst, in_valid, in_ready, flush;
    logic [3:0]    exe_cmd, sr_in, dest_in, status, dest;
    logic          wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm;
    logic [DW-1:0] pc_in, val_rn, val_rm, alu_result, br_addr, val_rm_out;
    logic [11:0]   shift_operand;
    logic [23:0]   imm_signed_24;
    logic [1:0]    sel_src_1, sel_src_2;
    logic [63:0]   fwd_val;
    logic          out_valid, out_ready, status_we, wb_en, mem_r_en, mem_w_en, busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    exe_stage_mc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .exe_cmd(exe_cmd), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .s_in(s_in), .pc_in(pc_in), .val_rn(val_rn),
        .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
        .imm_signed_24(imm_signed_24), .sr_in(sr_in), .dest_in(dest_in),
        .sel_src_1(sel_src_1), .sel_src_2(sel_src_2), .fwd_val(fwd_val),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .br_addr(br_addr), .val_rm_out(val_rm_out), .status(status),
        .status_we(status_we), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no_finish exp finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    function automatic op_t zero_op();
        op_t o;
        o.cmd = 4'd0; o.wb = 1'b0; o.mr = 1'b0; o.mw = 1'b0; o.s = 1'b0; o.imm = 1'b0;
        o.pc = '0; o.rn = '0; o.rm = '0; o.so = '0; o.imm24 = '0; o.sr = '0; o.dst = '0;
        o.sel1 = '0; o.sel2 = '0; o.fwd = '0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.cmd   = 4'($urandom_range(0, 15));
        o.wb    = 1'($urandom_range(0, 1));
        o.mr    = ($urandom_range(0, 7) == 0);
        o.mw    = ($urandom_range(0, 7) == 0);
        o.s     = 1'($urandom_range(0, 1));
        o.imm   = 1'($urandom_range(0, 1));
        o.pc    = $urandom;
        o.rn    = $urandom;
        o.rm    = $urandom;
        o.so    = 12'($urandom);
        o.imm24 = 24'($urandom);
        o.sr    = 4'($urandom_range(0, 15));
        o.dst   = 4'($urandom_range(0, 15));
        o.sel1  = 2'($urandom_range(0, 3));
        o.sel2  = 2'($urandom_range(0, 3));
        o.fwd   = {$urandom, $urandom};
        return o;
    endfunction

    task automatic put_op(input op_t o);
        exe_cmd = o.cmd; wb_en_in = o.wb; mem_r_en_in = o.mr; mem_w_en_in = o.mw;
        s_in = o.s; imm = o.imm; pc_in = o.pc; val_rn = o.rn; val_rm = o.rm;
        shift_operand = o.so; imm_signed_24 = o.imm24; sr_in = o.sr; dest_in = o.dst;
        sel_src_1 = o.sel1; sel_src_2 = o.sel2; fwd_val = o.fwd;
        in_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        put_op(zero_op());
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                         input logic [63:0] f);
        if (sel == 2'd1) return f[31:0];
        if (sel == 2'd2) return f[63:32];
        return r;
    endfunction

    function automatic logic [31:0] m_val2(input op_t o, input logic [31:0] rm);
        logic [63:0] dbl;
        longint      sx;
        int          n;
        if (o.mr || o.mw) return {20'd0, o.so};
        if (o.imm) begin
            n   = 2 * int'(o.so[11:8]);
            dbl = {24'd0, o.so[7:0], 24'd0, o.so[7:0]} >> n;
            return dbl[31:0];
        end
        n = int'(o.so[11:7]);
        case (o.so[6:5])
            2'd0: return rm << n;
            2'd1: return rm >> n;
            2'd2: begin sx = longint'($signed(rm)) >>> n; return sx[31:0]; end
            default: begin dbl = {rm, rm} >> n; return dbl[31:0]; end
        endcase
    endfunction

    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic [31:0] rn, rm, v2, r;
        logic [63:0] u;
        longint      sv;
        logic        c, bo;
        int          off;
        rn = pick(o.sel1, o.rn, o.fwd);
        rm = pick(o.sel2, o.rm, o.fwd);
        v2 = m_val2(o, rm);
        r = '0; c = 1'b0; sv = 0; bo = ~o.sr[1];
        case (o.cmd)
            4'd1:  r = v2;
            4'd9:  r = ~v2;
            4'd6:  r = rn & v2;
            4'd7:  r = rn | v2;
            4'd8:  r = rn ^ v2;
            4'd10: begin u = {32'd0, rn} * {32'd0, v2}; r = u[31:0]; end
            4'd2:  begin
                u = {32'd0, rn} + {32'd0, v2}; r = u[31:0]; c = u[32];
                sv = longint'($signed(rn)) + longint'($signed(v2));
            end
            4'd3:  begin
                u = {32'd0, rn} + {32'd0, v2} + {63'd0, o.sr[1]}; r = u[31:0]; c = u[32];
                sv = longint'($signed(rn)) + longint'($signed(v2)) + longint'(o.sr[1]);
            end
            4'd4:  begin
                r = rn - v2; c = (rn >= v2);
                sv = longint'($signed(rn)) - longint'($signed(v2));
            end
            4'd5:  begin
                r = rn - v2 - {31'd0, bo}; c = ({32'd0, rn} >= {32'd0, v2} + {63'd0, bo});
                sv = longint'($signed(rn)) - longint'($signed(v2)) - longint'(bo);
            end
            default: ;
        endcase
        e.res = r;
        e.st  = o.sr;
        if (o.cmd inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10})
            e.st = {r[31], r == 32'd0, o.sr[1:0]};
        else if (o.cmd inside {4'd2, 4'd3, 4'd4, 4'd5})
            e.st = {r[31], r == 32'd0, c, (sv > 64'sd2147483647) || (sv < -64'sd2147483648)};
        off   = int'($signed(o.imm24));
        e.br  = o.pc + 32'(off * 4);
        e.rmo = rm;
        e.swe = o.s;
        e.dst = o.dst;
        e.wb  = o.wb;
        e.mr  = o.mr;
        e.mw  = o.mw;
        return e;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        op_t o;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || status_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got v=%b busy=%b swe=%b exp 0 0 0", out_valid, busy, status_we);
        end
        rst = 1'b1;
        @(negedge clk);
        o = zero_op(); o.cmd = 4'd2; o.rn = 32'd3; o.imm = 1'b1; o.so = 12'h004;
        o.dst = 4'd5; o.wb = 1'b1; o.pc = 32'h40; o.rm = 32'd9; o.s = 1'b1;
        put_op(o);
        @(negedge clk);
        o.cmd = 4'd10; o.rn = 32'h1234;
        put_op(o);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mul_accept got in_ready=%b exp 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy_pre got %b exp 1", busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, busy, status_we, alu_result, br_addr, val_rm_out, status, dest,
             wb_en, mem_r_en, mem_w_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b busy=%b swe=%b res=%h br=%h rm=%h st=%h d=%h wb=%b mr=%b mw=%b exp all 0",
                     out_valid, busy, status_we, alu_result, br_addr, val_rm_out, status, dest,
                     wb_en, mem_r_en, mem_w_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        begin
            bit seen = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (out_valid !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++; $display("FAIL reset_mul_killed got out_valid=1 exp 0");
            end
        end
    endtask

    task automatic test_add_flags();
        op_t o;
        idle_inputs();
        @(negedge clk);
        o = zero_op(); o.cmd = 4'd2; o.rn = 32'h7FFFFFFF; o.imm = 1'b1; o.so = 12'h001; o.s = 1'b1;
        put_op(o);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL add_accept got rdy=%b v=%b exp 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'h80000000) begin
            errors++; $display("FAIL add_result got v=%b res=%h exp 1 80000000", out_valid, alu_result);
        end
        checks++;
        if (status !== 4'b1001 || status_we !== 1'b1) begin
            errors++; $display("FAIL add_flags got st=%b we=%b exp 1001 1", status, status_we);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || status_we !== 1'b0) begin
            errors++; $display("FAIL add_drain got v=%b we=%b exp 0 0", out_valid, status_we);
        end
    endtask

    task automatic test_fwd_shift();
        op_t o;
        logic [31:0] exp_res [4];
        logic [31:0] exp_rmo [4];
        op_t ops [4];
        o = zero_op(); o.cmd = 4'd1; o.sel2 = 2'd2; o.fwd = {32'h80000000, 32'h00000100};
        o.rm = 32'h12345678; o.so = 12'h240;
        ops[0] = o; exp_res[0] = 32'hF8000000; exp_rmo[0] = 32'h80000000;
        o.sel2 = 2'd3; o.rm = 32'h40000000;
        ops[1] = o; exp_res[1] = 32'h04000000; exp_rmo[1] = 32'h40000000;
        o = zero_op(); o.cmd = 4'd2; o.sel1 = 2'd1; o.fwd = {32'h80000000, 32'h00000100};
        o.rn = 32'h999; o.imm = 1'b1; o.so = 12'h001; o.rm = 32'h77;
        ops[2] = o; exp_res[2] = 32'h00000101; exp_rmo[2] = 32'h77;
        o = zero_op(); o.cmd = 4'd1; o.rm = 32'h000000F1; o.so = 12'h260;
        ops[3] = o; exp_res[3] = 32'h1000000F; exp_rmo[3] = 32'h000000F1;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            put_op(ops[i]);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || alu_result !== exp_res[i] || val_rm_out !== exp_rmo[i]) begin
                errors++;
                $display("FAIL fwd_shift_%0d got v=%b res=%h rm=%h exp 1 %h %h",
                         i, out_valid, alu_result, val_rm_out, exp_res[i], exp_rmo[i]);
            end
        end
    endtask

    task automatic test_mul_latency();
        op_t o;
        idle_inputs();
        @(negedge clk);
        o = zero_op(); o.cmd = 4'd10; o.rn = 32'h12345; o.imm = 1'b1; o.so = 12'hC01;
        o.s = 1'b1; o.sr = 4'b0011; o.dst = 4'd9;
        put_op(o);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mul_accept got %b exp 1", in_ready);
        end
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL mul_wait_%0d got v=%b busy=%b rdy=%b exp 0 1 0", i, out_valid, busy, in_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'h01234500 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_result got v=%b res=%h busy=%b exp 1 01234500 0", out_valid, alu_result, busy);
        end
        checks++;
        if (status !== 4'b0011 || status_we !== 1'b1 || dest !== 4'd9 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_flags got st=%b we=%b d=%0d rdy=%b exp 0011 1 9 1", status, status_we, dest, in_ready);
        end
    endtask

    task automatic test_backpressure();
        op_t o;
        idle_inputs();
        @(negedge clk);
        o = zero_op(); o.cmd = 4'd4; o.rn = 32'd5; o.rm = 32'd7; o.s = 1'b1;
        put_op(o);
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            o = zero_op(); o.cmd = 4'd2; o.rn = 32'd1; o.imm = 1'b1; o.so = 12'h002;
            put_op(o);
            if (i == 3) out_ready = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b1 || alu_result !== 32'hFFFFFFFE || status !== 4'b1000) begin
                errors++;
                $display("FAIL bp_hold_%0d got v=%b res=%h st=%b exp 1 fffffffe 1000", i, out_valid, alu_result, status);
            end
            checks++;
            if (in_ready !== (i == 3)) begin
                errors++; $display("FAIL bp_ready_%0d got %b exp %b", i, in_ready, (i == 3));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd3) begin
            errors++; $display("FAIL bp_no_bubble got v=%b res=%h exp 1 00000003", out_valid, alu_result);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained got %b exp 0", out_valid);
        end
    endtask

    task automatic test_flush();
        op_t o;
        bit  seen;
        idle_inputs();
        @(negedge clk);
        o = zero_op(); o.cmd = 4'd10; o.rn = 32'h1111; o.imm = 1'b1; o.so = 12'hC01;
        put_op(o);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        flush = 1'b1;
        put_op(o);
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL flush_ready got rdy=%b busy=%b exp 0 1", in_ready, busy);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle got busy=%b v=%b exp 0 0", busy, out_valid);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL flush_quiet got activity exp none");
        end
        o = zero_op(); o.cmd = 4'd2; o.rn = 32'd20; o.imm = 1'b1; o.so = 12'h001;
        put_op(o);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_outreg got %b exp 0", out_valid);
        end
        o = zero_op(); o.cmd = 4'd2; o.rn = 32'd10; o.imm = 1'b1; o.so = 12'h005;
        o.pc = 32'h100; o.imm24 = 24'hFFFFFF;
        put_op(o);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd15 || br_addr !== 32'hFC) begin
            errors++;
            $display("FAIL flush_after_add got v=%b res=%h br=%h exp 1 0000000f 000000fc", out_valid, alu_result, br_addr);
        end
    endtask

    task automatic test_random();
        op_t  o;
        exp_t e, got;
        bit   took;
        int   budget;
        idle_inputs();
        exp_q.delete();
        took = 1'b0;
        o = zero_op();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid || took) begin
                if ($urandom_range(0, 9) < 7) begin
                    o = rand_op();
                    put_op(o);
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (out_valid && out_ready) begin
                got = {alu_result, status, br_addr, val_rm_out, status_we, dest, wb_en, mem_r_en, mem_w_en};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious got %h exp nothing", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++; $display("FAIL rand_out got %h exp %h", got, e);
                    end
                end
            end
            took = in_valid && in_ready;
            if (took) exp_q.push_back(model(o));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            #1;
            if (out_valid) begin
                got = {alu_result, status, br_addr, val_rm_out, status_we, dest, wb_en, mem_r_en, mem_w_en};
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++; $display("FAIL rand_drain got %h exp %h", got, e);
                end
            end
            budget--;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rand_leftover got %0d pending exp 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add_flags();
        test_fwd_shift();
        test_mul_latency();
        test_backpressure();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
